rep_addr_seq: RTL and testbench
===============================

# rep_addr_seq

Parametrised REP string-operation address sequencer for the register-read/address-generation stage. It takes the effective addresses already computed for up to NUM_CH memory operands, plus an iteration count, element size and direction. It then emits one address set per beat under a valid/ready handshake, stepping each enabled channel by ±size until the count is exhausted. It generalises the single-pair, fixed-width rep mechanism to N channels, configurable address and count widths, a downstream handshake, abort, and a count-writeback output.

## Interface
Parameters:
- NUM_CH, 2, number of address channels (1..4)
- ADDR_W, 32, address width per channel
- CNT_W, 32, iteration counter width

Ports:
- clk  in  1  clock; all state updates on rising edge
- clr  in  1  reset, asynchronous, active-high
- start_valid  in  1  new instruction presented
- start_ready  out  1  sequencer can accept (state IDLE)
- is_rep  in  1  1 = REP-prefixed, iterate count times; 0 = single beat
- base_addr  in  NUM_CH*ADDR_W  initial address per channel, channel 0 in LSBs
- ch_en  in  NUM_CH  channel steps when set; disabled channels hold base
- count  in  CNT_W  iteration count (ECX/CX value)
- size  in  2  element size: 00=1, 01=2, 10=4, 11=8 bytes
- dir  in  1  0 = increment, 1 = decrement (DF)
- abort  in  1  synchronous flush (branch mispredict / exception)
- addr_out  out  NUM_CH*ADDR_W  current beat addresses
- addr_valid  out  1  addr_out valid
- addr_ready  in  1  downstream accepts beat
- last  out  1  current beat is final beat
- cnt_wb  out  CNT_W  remaining count after last accepted beat (count-register writeback)
- done  out  1  one-cycle pulse: instruction complete
- stall  out  1  sequencer busy; upstream must hold

## Operation
- FSM states: IDLE, RUN.
- IDLE: start_ready=1. On start_valid:
  - is_rep=1, count=0: no beats; cnt_wb<=0; done pulses next cycle; remain IDLE.
  - Otherwise: load addr regs from base_addr, rem<=is_rep?count:1, cnt_wb<=count; go RUN.
- RUN: addr_valid=1, stall=1, last=(rem==1).
  - Handshake (addr_valid&addr_ready):
    - Enabled channels: addr<=addr±(1<<size), modulo 2^ADDR_W; wrap is silent.
    - rem<=rem-1.
    - If is_rep, cnt_wb<=rem-1; if not is_rep, cnt_wb unchanged.
    - If last: go IDLE, done pulses next cycle.
  - No handshake: all state held; addr_out stable.
- abort: highest priority in any state; next cycle IDLE, addr_valid=0, done=0, cnt_wb holds last written value.
- abort and start_valid in the same cycle: the start is dropped.
- is_rep, size, dir and ch_en are captured at accept; later input changes have no effect mid-run.
- Counter width: count=2^CNT_W-1 runs full length, with no overflow check.

## Timing
- Reset (clr=1, async): state=IDLE, addr_out=0, addr_valid=0, last=0, cnt_wb=0, done=0, stall=0, start_ready=0 while clr asserted, then 1.
- All outputs are registered except start_ready, stall and last, which are decoded from the state/rem registers.
- Accept at edge N: addr_valid=1 with base addresses from cycle N+1.
- Throughput is one beat per cycle while addr_ready=1.
- A count-k REP takes k+1 cycles from accept to done with no backpressure.
- The next start may be accepted in the cycle done is high, because state is IDLE.
- clr mid-RUN: immediate return to reset values; no done pulse.

## Test plan
- Non-REP, base0=0x1000, base1=0x2000, ch_en=11, size=10: accept -> single beat 0x1000/0x2000 with last=1 -> done next cycle, cnt_wb unchanged.
- REP count=3, size=01, dir=0, ch_en=11, bases 0x100/0x200, ready=1 -> beats (0x100,0x200), (0x102,0x202), (0x104,0x204); last on third beat; cnt_wb sequence 2,1,0; done at accept+4.
- REP count=2, dir=1, size=11, ch_en=01, base0=0x4, base1=0x50 -> ch0 gives 0x4 then 0xFFFFFFFC (wrap); ch1 holds 0x50 on both beats.
- REP count=0 -> no addr_valid; done one cycle after accept; cnt_wb=0.
- REP count=4, addr_ready low for 3 cycles after the second beat, then abort asserted on a stalled beat -> addresses are held during backpressure; next cycle IDLE; addr_valid=0; no done; cnt_wb=3.
- Async clr asserted between clock edges during RUN -> outputs are reset values without waiting for a clock edge; a fresh start after release behaves normally.

Source files
------------

// File: rtl/rep_addr_seq.sv
// REP string-operation address sequencer: steps up to NUM_CH operand addresses
// by +/- element size once per accepted beat until the iteration count is spent.
module rep_addr_seq #(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned CNT_W  = 32
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic                     start_valid,
  output logic                     start_ready,
  input  logic                     is_rep,
  input  logic [NUM_CH*ADDR_W-1:0] base_addr,
  input  logic [NUM_CH-1:0]        ch_en,
  input  logic [CNT_W-1:0]         count,
  input  logic [1:0]               size,
  input  logic                     dir,
  input  logic                     abort,
  output logic [NUM_CH*ADDR_W-1:0] addr_out,
  output logic                     addr_valid,
  input  logic                     addr_ready,
  output logic                     last,
  output logic [CNT_W-1:0]         cnt_wb,
  output logic                     done,
  output logic                     stall
);

  localparam int unsigned AW_ALL = NUM_CH * ADDR_W;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [AW_ALL-1:0]   addr_q, addr_d;
  logic [CNT_W-1:0]    rem_q, rem_d;
  logic [CNT_W-1:0]    cnt_wb_q, cnt_wb_d;
  logic                valid_q, valid_d;
  logic                done_q, done_d;
  logic                rep_q, rep_d;
  logic [1:0]          size_q, size_d;
  logic                dir_q, dir_d;
  logic [NUM_CH-1:0]   en_q, en_d;

  logic [ADDR_W-1:0]   step_c;
  logic                hs_c;

  // State register
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      rem_q    <= '0;
      cnt_wb_q <= '0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
      rep_q    <= 1'b0;
      size_q   <= 2'b00;
      dir_q    <= 1'b0;
      en_q     <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      rem_q    <= rem_d;
      cnt_wb_q <= cnt_wb_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
      rep_q    <= rep_d;
      size_q   <= size_d;
      dir_q    <= dir_d;
      en_q     <= en_d;
    end
  end

  // Next-state: abort overrides everything, including a same-cycle start
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    rem_d    = rem_q;
    cnt_wb_d = cnt_wb_q;
    valid_d  = valid_q;
    done_d   = 1'b0;
    rep_d    = rep_q;
    size_d   = size_q;
    dir_d    = dir_q;
    en_d     = en_q;
    step_c   = ADDR_W'(1) << size_q;
    hs_c     = valid_q & addr_ready;

    if (abort) begin
      state_d = IDLE;
      valid_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_valid) begin
            if (is_rep && (count == '0)) begin
              cnt_wb_d = '0;
              done_d   = 1'b1;
            end else begin
              addr_d   = base_addr;
              rem_d    = is_rep ? count : CNT_W'(1);
              cnt_wb_d = count;
              rep_d    = is_rep;
              size_d   = size;
              dir_d    = dir;
              en_d     = ch_en;
              valid_d  = 1'b1;
              state_d  = RUN;
            end
          end
        end
        RUN: begin
          if (hs_c) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
              if (en_q[i]) begin
                addr_d[i*ADDR_W +: ADDR_W] = dir_q ? (addr_q[i*ADDR_W +: ADDR_W] - step_c)
                                                   : (addr_q[i*ADDR_W +: ADDR_W] + step_c);
              end
            end
            rem_d = rem_q - CNT_W'(1);
            if (rep_q) begin
              cnt_wb_d = rem_q - CNT_W'(1);
            end
            if (rem_q == CNT_W'(1)) begin
              state_d = IDLE;
              valid_d = 1'b0;
              done_d  = 1'b1;
            end
          end
        end
        default: begin
          state_d = IDLE;
          valid_d = 1'b0;
        end
      endcase
    end
  end

  assign addr_out    = addr_q;
  assign addr_valid  = valid_q;
  assign cnt_wb      = cnt_wb_q;
  assign done        = done_q;
  assign stall       = (state_q == RUN);
  assign last        = (state_q == RUN) && (rem_q == CNT_W'(1));
  assign start_ready = (state_q == IDLE) && !clr;

endmodule

// File: tb/tb_rep_addr_seq.sv
// Scoreboard bench for rep_addr_seq: stimulus pushes expected beats/done
// values, a negedge monitor pops and compares them as the DUT presents them.
module tb_rep_addr_seq;

  logic        clk;
  logic        clr;
  logic        start_valid;
  logic        start_ready;
  logic        is_rep;
  logic [63:0] base_addr;
  logic [1:0]  ch_en;
  logic [31:0] count;
  logic [1:0]  size;
  logic        dir;
  logic        abort;
  logic [63:0] addr_out;
  logic        addr_valid;
  logic        addr_ready;
  logic        last;
  logic [31:0] cnt_wb;
  logic        done;
  logic        stall;

  rep_addr_seq #(.NUM_CH(2), .ADDR_W(32), .CNT_W(32)) dut (
    .clk(clk), .clr(clr),
    .start_valid(start_valid), .start_ready(start_ready),
    .is_rep(is_rep), .base_addr(base_addr), .ch_en(ch_en),
    .count(count), .size(size), .dir(dir), .abort(abort),
    .addr_out(addr_out), .addr_valid(addr_valid), .addr_ready(addr_ready),
    .last(last), .cnt_wb(cnt_wb), .done(done), .stall(stall)
  );

  typedef struct {
    logic [63:0] addr;
    logic        lst;
    logic [31:0] cnt;
  } beat_t;

  beat_t       exp_q[$];
  logic [31:0] done_q[$];
  int          total = 0;
  int          bad   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic exp_beat(input logic [31:0] a0, input logic [31:0] a1,
                          input logic l, input logic [31:0] c);
    beat_t b;
    b.addr = {a1, a0};
    b.lst  = l;
    b.cnt  = c;
    exp_q.push_back(b);
  endtask

  // Called just after a rising edge; the following edge is the accept edge.
  task automatic start(input logic rep, input logic [31:0] cnt, input logic [1:0] sz,
                       input logic d, input logic [1:0] en,
                       input logic [31:0] b0, input logic [31:0] b1);
    start_valid = 1'b1;
    is_rep      = rep;
    count       = cnt;
    size        = sz;
    dir         = d;
    ch_en       = en;
    base_addr   = {b1, b0};
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    is_rep      = ~rep;
    count       = 32'hDEAD_BEEF;
    size        = ~sz;
    dir         = ~d;
    ch_en       = ~en;
  endtask

  task automatic drain();
    for (int i = 0; i < 40; i++) begin
      if (exp_q.size() == 0 && done_q.size() == 0) break;
      @(posedge clk);
    end
    chk("drain_pending", 64'(exp_q.size() + done_q.size()), 64'd0);
    exp_q.delete();
    done_q.delete();
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Monitor
  initial begin
    beat_t       b;
    logic [31:0] dv;
    forever begin
      @(negedge clk);
      if (!clr) begin
        if (addr_valid && addr_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_beat", 64'(addr_valid), 64'd0);
          end else begin
            b = exp_q.pop_front();
            chk("beat_addr", addr_out, b.addr);
            chk("beat_last", 64'(last), 64'(b.lst));
            chk("beat_cnt_wb", 64'(cnt_wb), 64'(b.cnt));
          end
        end
        if (done) begin
          if (done_q.size() == 0) begin
            chk("unexpected_done", 64'(done), 64'd0);
          end else begin
            dv = done_q.pop_front();
            chk("done_cnt_wb", 64'(cnt_wb), 64'(dv));
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    clr = 1'b1; start_valid = 1'b0; is_rep = 1'b0; base_addr = '0; ch_en = '0;
    count = '0; size = '0; dir = 1'b0; abort = 1'b0; addr_ready = 1'b1;
    #3;
    chk("rst_start_ready", 64'(start_ready), 64'd0);
    chk("rst_addr_out", addr_out, 64'd0);
    chk("rst_addr_valid", 64'(addr_valid), 64'd0);
    chk("rst_last", 64'(last), 64'd0);
    chk("rst_cnt_wb", 64'(cnt_wb), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_stall", 64'(stall), 64'd0);
    @(posedge clk); #1;
    clr = 1'b0;
    @(negedge clk);
    chk("idle_start_ready", 64'(start_ready), 64'd1);
    @(posedge clk); #1;

    // Non-REP single beat
    exp_beat(32'h1000, 32'h2000, 1'b1, 32'd0);
    done_q.push_back(32'd0);
    start(1'b0, 32'd0, 2'b10, 1'b0, 2'b11, 32'h1000, 32'h2000);
    drain();

    // REP count=3, size 2, increment; done exactly 4 cycles after accept
    exp_beat(32'h100, 32'h200, 1'b0, 32'd3);
    exp_beat(32'h102, 32'h202, 1'b0, 32'd2);
    exp_beat(32'h104, 32'h204, 1'b1, 32'd1);
    done_q.push_back(32'd0);
    start(1'b1, 32'd3, 2'b01, 1'b0, 2'b11, 32'h100, 32'h200);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      chk("done_timing", 64'(done), 64'(c == 4));
      @(posedge clk);
    end
    #1;
    drain();

    // REP count=2, decrement by 8, only ch0 enabled; ch0 wraps below zero
    exp_beat(32'h4, 32'h50, 1'b0, 32'd2);
    exp_beat(32'hFFFF_FFFC, 32'h50, 1'b1, 32'd1);
    done_q.push_back(32'd0);
    start(1'b1, 32'd2, 2'b11, 1'b1, 2'b01, 32'h4, 32'h50);
    drain();

    // REP count=4, backpressure on second beat, then abort
    exp_beat(32'h10, 32'h20, 1'b0, 32'd4);
    start(1'b1, 32'd4, 2'b00, 1'b0, 2'b11, 32'h10, 32'h20);
    @(posedge clk); #1;
    addr_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("hold_addr", addr_out, {32'h21, 32'h11});
      chk("hold_valid", 64'(addr_valid), 64'd1);
      chk("hold_cnt_wb", 64'(cnt_wb), 64'd3);
      @(posedge clk);
    end
    #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    addr_ready = 1'b1;
    @(negedge clk);
    chk("abort_valid", 64'(addr_valid), 64'd0);
    chk("abort_stall", 64'(stall), 64'd0);
    chk("abort_cnt_wb", 64'(cnt_wb), 64'd3);
    chk("abort_done", 64'(done), 64'd0);
    @(negedge clk);
    chk("abort_done2", 64'(done), 64'd0);
    @(posedge clk); #1;
    drain();

    // REP count=0: no beats, immediate done, cnt_wb cleared
    done_q.push_back(32'd0);
    start(1'b1, 32'd0, 2'b00, 1'b0, 2'b11, 32'h700, 32'h800);
    @(negedge clk);
    chk("cnt0_done", 64'(done), 64'd1);
    chk("cnt0_valid", 64'(addr_valid), 64'd0);
    @(posedge clk); #1;
    drain();

    // abort in the same cycle as start drops the start
    abort = 1'b1;
    start(1'b0, 32'd1, 2'b00, 1'b0, 2'b11, 32'h900, 32'hA00);
    abort = 1'b0;
    @(negedge clk);
    chk("abort_start_valid", 64'(addr_valid), 64'd0);
    chk("abort_start_stall", 64'(stall), 64'd0);
    @(posedge clk); #1;

    // Async clr mid-run: outputs return to reset values before the next edge
    exp_beat(32'h300, 32'h400, 1'b0, 32'd5);
    exp_beat(32'h304, 32'h404, 1'b0, 32'd4);
    start(1'b1, 32'd5, 2'b10, 1'b0, 2'b11, 32'h300, 32'h400);
    @(posedge clk);
    @(posedge clk);
    #3;
    clr = 1'b1;
    #1;
    chk("clr_addr_valid", 64'(addr_valid), 64'd0);
    chk("clr_addr_out", addr_out, 64'd0);
    chk("clr_stall", 64'(stall), 64'd0);
    chk("clr_last", 64'(last), 64'd0);
    chk("clr_start_ready", 64'(start_ready), 64'd0);
    chk("clr_cnt_wb", 64'(cnt_wb), 64'd0);
    chk("clr_done", 64'(done), 64'd0);
    @(posedge clk); #1;
    clr = 1'b0;
    @(posedge clk); #1;
    chk("clr_scoreboard_empty", 64'(exp_q.size()), 64'd0);

    // Fresh start after clr: ch1 only, decrement by 1 from zero
    exp_beat(32'h0, 32'h0, 1'b0, 32'd2);
    exp_beat(32'h0, 32'hFFFF_FFFF, 1'b1, 32'd1);
    done_q.push_back(32'd0);
    start(1'b1, 32'd2, 2'b00, 1'b1, 2'b10, 32'h0, 32'h0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
